ps2_key_tx: RTL and testbench
=============================

PS2_KEY_TX -- requirements
Module: ps2_key_tx

Interface
REQ-001 Parameter HALF_DIV, default 4, meaning clk cycles per PS/2 clock half-period (legal range 2..255).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 key_valid  input  1  request to send the key in key_code.
REQ-005 key_code  input  4  hex digit to transmit (0x0..0xF).
REQ-006 key_release  input  1  0 = send make code, 1 = send break sequence (F0 then code); sampled with key_valid.
REQ-007 ps2_inhibit  input  1  host inhibit (host holding PS/2 clock low), already synchronized.
REQ-008 key_ready  output  1  block can accept a request this cycle.
REQ-009 ps2_clk  output  1  PS/2 clock line as driven by the device, registered.
REQ-010 ps2_data  output  1  PS/2 data line as driven by the device, registered.
REQ-011 busy  output  1  a sequence is in progress (including gap and inhibit-wait).

Function
REQ-012 Code table SHALL be: 0->45, 1->1C, 2->32, 3->21, 4->23, 5->24, 6->2B, 7->34, 8->33, 9->43, A->3B, B->42, C->4B, D->3A, E->31, F->44 (hex).
REQ-013 key_ready SHALL be 1 only in IDLE with ps2_inhibit=0; a request is accepted in cycle T when key_valid=1 and key_ready=1; key_code and key_release are latched in T.
REQ-014 key_valid while key_ready=0 SHALL be ignored, with no queuing.
REQ-015 States: IDLE, FRAME, GAP, HOLD; IDLE->FRAME on acceptance; FRAME->GAP after a break-prefix frame; GAP->FRAME after the gap; FRAME->IDLE after the last frame; FRAME->HOLD on abort; HOLD->FRAME on inhibit release.
REQ-016 Frame: 11 bits: start 0, data bits d0..d7 LSB first, odd parity (1 when data has an even count of ones), stop 1.
REQ-017 Each bit SHALL last 2*HALF_DIV cycles: ps2_clk=1 for the first HALF_DIV cycles and 0 for the last HALF_DIV; ps2_data is constant for the whole bit period.
REQ-018 The first bit-period cycle of the start bit SHALL be cycle T+1; busy=1 and key_ready=0 from T+1.
REQ-019 A make sequence is one frame carrying the table code; a break sequence is frame F0, then GAP, then frame with the table code.
REQ-020 GAP SHALL last 2*HALF_DIV cycles with ps2_clk=1 and ps2_data=1.
REQ-021 After the final stop bit, the block SHALL return to IDLE; busy=0 in the following cycle, and key_ready=1 if ps2_inhibit=0.
REQ-022 If ps2_inhibit=1 during any FRAME cycle before the parity bit period begins, the block SHALL abort in the next cycle:
  - ps2_clk=1 and ps2_data=1;
  - state moves to HOLD; busy stays 1.
REQ-023 In HOLD, on the first cycle ps2_inhibit=0, the block SHALL restart the whole sequence from the start bit of the first frame (including F0 for a break) in the next cycle.
REQ-024 ps2_inhibit asserted during the parity or stop bit, or during GAP, SHALL be ignored for that frame; it is re-evaluated at the next frame start.
REQ-025 Timing with HALF_DIV=4: make sequence busy for 88 cycles (ready at T+89); break sequence busy for 184 cycles (ready at T+185).
REQ-026 Internal counters SHALL be sized for HALF_DIV up to 255 without wrap-around inside a bit period.

Reset
REQ-027 Reset at any time, including mid-frame, SHALL within one cycle force:
  - state IDLE, ps2_clk=1, ps2_data=1, busy=0;
  - key_ready=1 (if ps2_inhibit=0);
  - any pending or partial sequence discarded.
REQ-028 Reset SHALL take priority over key_valid and ps2_inhibit in the same cycle.

Verification
REQ-029 Make key 0x1, HALF_DIV=4 -> ps2_data per bit 0,0,0,1,1,1,0,0,0,0,1 (1C, parity 0); each bit 8 cycles, clk 1x4 then 0x4; key_ready back at T+89.
REQ-030 Release key 0xA -> frame F0 (bits 0,0,0,0,0,1,1,1,1,1,1), 8-cycle idle gap, frame 3B (bits 0,1,1,0,1,1,1,0,0,0,1); ready at T+185.
REQ-031 Make key 0x0 -> 45 sent as bits 0,1,0,1,0,0,0,1,0,0,1.
REQ-032 Inhibit high during data bit 3 for 20 cycles -> lines high the next cycle; after release, full frame restarts from the start bit; the captured frame is correct.
REQ-033 Reset asserted in bit 5 of a frame -> next cycle ps2_clk=1, ps2_data=1, busy=0, key_ready=1; no further bits sent.
REQ-034 key_valid pulsed with code 0x7 mid-frame -> ignored; only the original key is transmitted.

Source files
------------

// File: rtl/ps2_key_tx.sv
// PS/2 device-side key transmitter.
// Sends a make code (one frame) or a break sequence (F0 frame, idle gap, code frame)
// for a hex key, driving registered PS/2 clock and data lines. Host inhibit aborts a
// frame before its parity bit and restarts the whole sequence once released.
module ps2_key_tx #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_release,
  input  logic       ps2_inhibit,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Cycle counter spans a full bit period (up to 510 cycles at HALF_DIV=255).
  localparam logic [8:0] HALF = 9'(HALF_DIV);
  localparam logic [8:0] LAST = 9'(2 * HALF_DIV - 1);

  localparam logic [3:0] BIT_PARITY = 4'd9;
  localparam logic [3:0] BIT_STOP   = 4'd10;

  logic [1:0] state_q, state_d;
  logic [3:0] bit_q, bit_d;       // 0 start, 1..8 data, 9 parity, 10 stop
  logic [8:0] cyc_q, cyc_d;       // position inside the current bit or gap
  logic       prefix_q, prefix_d; // current frame carries the F0 break prefix
  logic       brk_q, brk_d;       // latched key_release, needed for restarts
  logic [7:0] code_q, code_d;     // latched scan code
  logic       clk_q, clk_d;
  logic       data_q, data_d;

  logic [7:0] byte_d;
  logic [3:0] data_idx;

  function automatic logic [7:0] scan_code(input logic [3:0] k);
    logic [7:0] s;
    case (k)
      4'h0:    s = 8'h45;
      4'h1:    s = 8'h1C;
      4'h2:    s = 8'h32;
      4'h3:    s = 8'h21;
      4'h4:    s = 8'h23;
      4'h5:    s = 8'h24;
      4'h6:    s = 8'h2B;
      4'h7:    s = 8'h34;
      4'h8:    s = 8'h33;
      4'h9:    s = 8'h43;
      4'hA:    s = 8'h3B;
      4'hB:    s = 8'h42;
      4'hC:    s = 8'h4B;
      4'hD:    s = 8'h3A;
      4'hE:    s = 8'h31;
      default: s = 8'h44;
    endcase
    return s;
  endfunction

  assign key_ready = (state_q == IDLE) && !ps2_inhibit;
  assign busy      = (state_q != IDLE);
  assign ps2_clk   = clk_q;
  assign ps2_data  = data_q;

  // Sequence control: state, bit index and cycle counter for the next cycle.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    prefix_d = prefix_q;
    brk_d    = brk_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (key_valid && !ps2_inhibit) begin
          state_d  = FRAME;
          bit_d    = 4'd0;
          cyc_d    = 9'd0;
          code_d   = scan_code(key_code);
          brk_d    = key_release;
          prefix_d = key_release;
        end
      end
      FRAME: begin
        // Inhibit only aborts before the parity bit; afterwards the frame completes.
        if (ps2_inhibit && (bit_q < BIT_PARITY)) begin
          state_d = HOLD;
          bit_d   = 4'd0;
          cyc_d   = 9'd0;
        end else if (cyc_q == LAST) begin
          cyc_d = 9'd0;
          if (bit_q == BIT_STOP) begin
            bit_d   = 4'd0;
            state_d = prefix_q ? GAP : IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 9'd1;
        end
      end
      GAP: begin
        if (cyc_q == LAST) begin
          state_d  = FRAME;
          bit_d    = 4'd0;
          cyc_d    = 9'd0;
          prefix_d = 1'b0;
        end else begin
          cyc_d = cyc_q + 9'd1;
        end
      end
      HOLD: begin
        // Restart the complete sequence, including the F0 prefix of a break.
        if (!ps2_inhibit) begin
          state_d  = FRAME;
          bit_d    = 4'd0;
          cyc_d    = 9'd0;
          prefix_d = brk_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line values derived from next-state so the registered outputs line up with the state.
  always_comb begin
    byte_d   = prefix_d ? 8'hF0 : code_d;
    data_idx = bit_d - 4'd1;
    clk_d    = 1'b1;
    data_d   = 1'b1;
    if (state_d == FRAME) begin
      clk_d = (cyc_d < HALF);
      if (bit_d == 4'd0) begin
        data_d = 1'b0;
      end else if (bit_d == BIT_PARITY) begin
        data_d = ~^byte_d;
      end else if (bit_d == BIT_STOP) begin
        data_d = 1'b1;
      end else begin
        data_d = byte_d[data_idx[2:0]];
      end
    end
  end

  // State and line registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= 4'd0;
      cyc_q    <= 9'd0;
      prefix_q <= 1'b0;
      brk_q    <= 1'b0;
      code_q   <= 8'h00;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      prefix_q <= prefix_d;
      brk_q    <= brk_d;
      code_q   <= code_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_tx.sv
// Directed bench for ps2_key_tx with HALF_DIV=4 (8-cycle bits).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ps2_key_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_release;
  logic       ps2_inhibit;
  logic       key_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  ps2_key_tx #(.HALF_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .ps2_inhibit (ps2_inhibit),
    .key_ready   (key_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Request presented for one cycle; returns just after the accepting edge (cycle T+1).
  task automatic send(input logic [3:0] code, input logic rel);
    @(negedge clk);
    key_code    = code;
    key_release = rel;
    key_valid   = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  // Samples 88 cycles starting at the current falling edge (first start-bit cycle).
  // bits[0] is the start bit; bad_* count cycles that break the bit-period shape.
  task automatic capture_frame(output logic [10:0] bits, output int bad_clk,
                               output int bad_const, output int bad_busy);
    bad_clk   = 0;
    bad_const = 0;
    bad_busy  = 0;
    bits      = '0;
    for (int i = 0; i < 88; i++) begin
      int b;
      int c;
      if (i > 0) @(negedge clk);
      b = i / 8;
      c = i % 8;
      if (c == 0) bits[b] = ps2_data;
      else if (ps2_data !== bits[b]) bad_const++;
      if (ps2_clk !== ((c < 4) ? 1'b1 : 1'b0)) bad_clk++;
      if (busy !== 1'b1) bad_busy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ps2_clk, ps2_data, busy, key_ready} !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_state: got clk,data,busy,ready=%b required 1101",
               {ps2_clk, ps2_data, busy, key_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, key_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy,ready=%b required 01", {busy, key_ready});
    end
  endtask

  task automatic test_make(input logic [3:0] code, input logic [10:0] exp_bits, input string nm);
    logic [10:0] bits;
    int bc, bd, bb;
    send(code, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({busy, key_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_start_flags: got busy,ready=%b required 10", nm, {busy, key_ready});
    end
    capture_frame(bits, bc, bd, bb);
    n_cmp++;
    if (bits !== exp_bits) begin
      n_fail++;
      $display("FAIL %s_bits: got %b required %b (stop..start)", nm, bits, exp_bits);
    end
    n_cmp++;
    if (bc != 0 || bd != 0 || bb != 0) begin
      n_fail++;
      $display("FAIL %s_shape: got bad clk/data/busy cycles %0d/%0d/%0d required 0/0/0",
               nm, bc, bd, bb);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, key_ready, ps2_clk, ps2_data} !== 4'b0111) begin
      n_fail++;
      $display("FAIL %s_ready_T89: got busy,ready,clk,data=%b required 0111",
               nm, {busy, key_ready, ps2_clk, ps2_data});
    end
  endtask

  task automatic test_break();
    logic [10:0] bits;
    int bc, bd, bb, bad_gap;
    send(4'hA, 1'b1);
    @(negedge clk);
    capture_frame(bits, bc, bd, bb);
    n_cmp++;
    if (bits !== 11'b111_1110_0000) begin
      n_fail++;
      $display("FAIL break_f0_bits: got %b required 11111100000", bits);
    end
    n_cmp++;
    if (bc != 0 || bd != 0 || bb != 0) begin
      n_fail++;
      $display("FAIL break_f0_shape: got %0d/%0d/%0d required 0/0/0", bc, bd, bb);
    end
    bad_gap = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ({ps2_clk, ps2_data, busy, key_ready} !== 4'b1110) bad_gap++;
    end
    n_cmp++;
    if (bad_gap != 0) begin
      n_fail++;
      $display("FAIL break_gap: got %0d bad gap cycles required 0", bad_gap);
    end
    @(negedge clk);
    capture_frame(bits, bc, bd, bb);
    n_cmp++;
    if (bits !== 11'b100_0111_0110) begin
      n_fail++;
      $display("FAIL break_code_bits: got %b required 10001110110", bits);
    end
    n_cmp++;
    if (bc != 0 || bd != 0 || bb != 0) begin
      n_fail++;
      $display("FAIL break_code_shape: got %0d/%0d/%0d required 0/0/0", bc, bd, bb);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, key_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL break_ready_T185: got busy,ready=%b required 01", {busy, key_ready});
    end
  endtask

  task automatic test_inhibit_abort();
    logic [10:0] bits;
    int bc, bd, bb, bad_hold;
    send(4'h5, 1'b0);
    @(negedge clk);
    repeat (33) @(negedge clk);
    ps2_inhibit = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ps2_clk, ps2_data, busy, key_ready} !== 4'b1110) begin
      n_fail++;
      $display("FAIL inhibit_abort_lines: got clk,data,busy,ready=%b required 1110",
               {ps2_clk, ps2_data, busy, key_ready});
    end
    bad_hold = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if ({ps2_clk, ps2_data, busy, key_ready} !== 4'b1110) bad_hold++;
    end
    n_cmp++;
    if (bad_hold != 0) begin
      n_fail++;
      $display("FAIL inhibit_hold: got %0d bad hold cycles required 0", bad_hold);
    end
    ps2_inhibit = 1'b0;
    @(negedge clk);
    capture_frame(bits, bc, bd, bb);
    n_cmp++;
    if (bits !== 11'b110_0100_1000) begin
      n_fail++;
      $display("FAIL inhibit_restart_bits: got %b required 11001001000", bits);
    end
    n_cmp++;
    if (bc != 0 || bd != 0 || bb != 0) begin
      n_fail++;
      $display("FAIL inhibit_restart_shape: got %0d/%0d/%0d required 0/0/0", bc, bd, bb);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, key_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL inhibit_done: got busy,ready=%b required 01", {busy, key_ready});
    end
  endtask

  task automatic test_inhibit_idle();
    @(negedge clk);
    ps2_inhibit = 1'b1;
    key_code    = 4'h1;
    key_release = 1'b0;
    key_valid   = 1'b1;
    #1;
    n_cmp++;
    if (key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inhibit_idle_ready: got %b required 0", key_ready);
    end
    @(negedge clk);
    key_valid = 1'b0;
    n_cmp++;
    if ({busy, ps2_data} !== 2'b01) begin
      n_fail++;
      $display("FAIL inhibit_idle_ignored: got busy,data=%b required 01", {busy, ps2_data});
    end
    ps2_inhibit = 1'b0;
    #1;
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL inhibit_idle_release: got ready=%b required 1", key_ready);
    end
  endtask

  task automatic test_reset_midframe();
    int bad_after;
    send(4'h3, 1'b0);
    @(negedge clk);
    repeat (42) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ps2_clk, ps2_data, busy, key_ready} !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_midframe: got clk,data,busy,ready=%b required 1101",
               {ps2_clk, ps2_data, busy, key_ready});
    end
    reset = 1'b0;
    bad_after = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({ps2_clk, ps2_data, busy} !== 3'b110) bad_after++;
    end
    n_cmp++;
    if (bad_after != 0) begin
      n_fail++;
      $display("FAIL reset_no_more_bits: got %0d active cycles required 0", bad_after);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset       = 1'b1;
    key_code    = 4'h1;
    key_release = 1'b1;
    key_valid   = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    key_valid = 1'b0;
    n_cmp++;
    if ({busy, ps2_data} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_priority: got busy,data=%b required 01", {busy, ps2_data});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, key_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_priority_after: got busy,ready=%b required 01", {busy, key_ready});
    end
  endtask

  task automatic test_ignore_midframe();
    logic [10:0] bits;
    int bc, bd, bb, bad_idle;
    send(4'h2, 1'b0);
    @(negedge clk);
    fork
      capture_frame(bits, bc, bd, bb);
      begin
        repeat (20) @(negedge clk);
        key_code  = 4'h7;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
      end
    join
    n_cmp++;
    if (bits !== 11'b100_0110_0100) begin
      n_fail++;
      $display("FAIL ignore_bits: got %b required 10001100100", bits);
    end
    n_cmp++;
    if (bc != 0 || bd != 0 || bb != 0) begin
      n_fail++;
      $display("FAIL ignore_shape: got %0d/%0d/%0d required 0/0/0", bc, bd, bb);
    end
    bad_idle = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({busy, key_ready, ps2_data} !== 3'b011) bad_idle++;
    end
    n_cmp++;
    if (bad_idle != 0) begin
      n_fail++;
      $display("FAIL ignore_no_queue: got %0d active cycles required 0", bad_idle);
    end
  endtask

  initial begin
    key_valid   = 1'b0;
    key_code    = 4'h0;
    key_release = 1'b0;
    ps2_inhibit = 1'b0;
    reset       = 1'b1;
    test_reset();
    test_make(4'h1, 11'b100_0011_1000, "make_1");
    test_make(4'h0, 11'b100_1000_1010, "make_0");
    test_break();
    test_inhibit_abort();
    test_inhibit_idle();
    test_reset_midframe();
    test_reset_priority();
    test_ignore_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
